// File: rtl/relu_argmax_seq_pkg.sv
// Shared parameters and types for the ReLU argmax classifier stage.
// Sizes must track the upstream dense layer.
package relu_argmax_seq_pkg;

  localparam int WIDTH       = 8;
  localparam int OUTPUT_SIZE = 5;
  localparam int IDX_W       = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

  typedef logic signed [WIDTH-1:0] act_t;
  typedef act_t vec_t [0:OUTPUT_SIZE-1];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // An activation counts as "not fired" when it is zero or negative.
  function automatic logic not_fired(input act_t a);
    return (a <= act_t'(0));
  endfunction

endpackage

// File: rtl/relu_argmax_seq_if.sv
// Vector-in / result-out handshake bundle for the argmax stage.
interface relu_argmax_seq_if;
  import relu_argmax_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  vec_t             in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  act_t             out_max;
  logic             out_all_zero;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_idx, out_max, out_all_zero
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_idx, out_max, out_all_zero
  );

endinterface

// File: rtl/relu_argmax_seq.sv
// Sequential argmax over one vector of signed ReLU activations, one element
// per cycle; result held until the consumer accepts it.
module relu_argmax_seq
  import relu_argmax_seq_pkg::*;
(
  input logic              clk,
  input logic              rst,
  relu_argmax_seq_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(OUTPUT_SIZE - 1);
  localparam state_t           FIRST_STATE = (OUTPUT_SIZE == 1) ? DONE : SCAN;

  state_t           state_r;
  state_t           next_state_s;
  vec_t             vec_r;
  logic [IDX_W-1:0] scan_idx_r;
  logic [IDX_W-1:0] best_idx_r;
  act_t             best_val_r;
  logic             all_zero_r;
  logic             out_valid_r;
  logic             in_ready_s;
  logic             accept_s;
  act_t             cur_s;

  // Handshake decode and current scan element.
  always_comb begin
    in_ready_s = (state_r == IDLE) || ((state_r == DONE) && bus.out_ready);
    accept_s   = bus.in_valid && in_ready_s;
    cur_s      = vec_r[scan_idx_r];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a DONE-state accept goes straight back to scanning.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = FIRST_STATE;
        else          next_state_s = IDLE;
      end
      SCAN: begin
        if (scan_idx_r == LAST_IDX) next_state_s = DONE;
        else                        next_state_s = SCAN;
      end
      DONE: begin
        if (accept_s)           next_state_s = FIRST_STATE;
        else if (bus.out_ready) next_state_s = IDLE;
        else                    next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Capture, compare/update, and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_r       <= '{default: '0};
      scan_idx_r  <= '0;
      best_idx_r  <= '0;
      best_val_r  <= '0;
      all_zero_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (next_state_s == DONE);
      if (accept_s) begin
        vec_r      <= bus.in_data;
        best_val_r <= bus.in_data[0];
        best_idx_r <= '0;
        all_zero_r <= not_fired(bus.in_data[0]);
        scan_idx_r <= IDX_W'(1);
      end else if (state_r == SCAN) begin
        // Strict compare keeps the lowest index on ties.
        if (cur_s > best_val_r) begin
          best_val_r <= cur_s;
          best_idx_r <= scan_idx_r;
        end
        all_zero_r <= all_zero_r & not_fired(cur_s);
        scan_idx_r <= scan_idx_r + IDX_W'(1);
      end
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_idx      = best_idx_r;
  assign bus.out_max      = best_val_r;
  assign bus.out_all_zero = all_zero_r;

endmodule

// File: tb/tb_relu_argmax_seq.sv
// Directed self-checking bench for relu_argmax_seq: latency, ties, extremes,
// back-pressure, streaming against an argmax model, and mid-scan reset.
module tb_relu_argmax_seq;
  import relu_argmax_seq_pkg::*;

  logic clk;
  logic rst;
  int   n_vec  = 0;
  int   n_fail = 0;

  relu_argmax_seq_if bus();

  relu_argmax_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present v, wait for accept, then count cycles until out_valid.
  // Cycle t+1 is the first cycle after the accepting edge.
  task automatic run_vec(input string tag, input vec_t v, input int e_idx,
                         input int e_max, input int e_az);
    int w;
    int lat;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    #1;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk); #1; w++;
    end
    check({tag, "_accept"}, bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    check({tag, "_latency"}, lat, OUTPUT_SIZE);
    check({tag, "_idx"}, bus.out_idx, e_idx);
    check({tag, "_max"}, bus.out_max, e_max);
    check({tag, "_allzero"}, bus.out_all_zero, e_az);
  endtask

  task automatic pulse_end(input string tag);
    @(negedge clk); #1;
    check({tag, "_pulse"}, bus.out_valid, 0);
  endtask

  vec_t s_vec [20];
  int   m_idx [20];
  int   m_max [20];
  int   m_az  [20];

  initial begin
    int   cyc;
    int   nin;
    int   nout;
    int   last;
    logic adv;

    clk          = 1'b0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '{default: '0};
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_idx", bus.out_idx, 0);
    check("rst_max", bus.out_max, 0);
    check("rst_allzero", bus.out_all_zero, 0);
    rst = 1'b0;
    #1;
    check("idle_ready", bus.in_ready, 1);

    bus.out_ready = 1'b1;
    run_vec("basic", '{8'sd3, 8'sd9, 8'sd1, 8'sd7, 8'sd2}, 1, 9, 0);
    pulse_end("basic");
    run_vec("tie", '{8'sd4, 8'sd6, 8'sd6, 8'sd0, 8'sd6}, 1, 6, 0);
    pulse_end("tie");
    run_vec("ext", '{8'sh80, 8'sd127, 8'sd0, 8'sd127, -8'sd1}, 1, 127, 0);
    pulse_end("ext");
    run_vec("zeros", '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0}, 0, 0, 1);
    pulse_end("zeros");
    run_vec("last1", '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd1}, 4, 1, 0);
    pulse_end("last1");

    // Back-pressure: result must hold and in_ready stay low.
    bus.out_ready = 1'b0;
    run_vec("bp", '{8'sd2, -8'sd3, 8'sd7, 8'sd7, 8'sd1}, 2, 7, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_idx", bus.out_idx, 2);
      check("bp_hold_max", bus.out_max, 7);
      check("bp_hold_ready", bus.in_ready, 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5};
    #1;
    check("b2b_ready", bus.in_ready, 1);
    check("b2b_valid", bus.out_valid, 1);
    run_vec("b2b", '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5}, 4, 5, 0);
    pulse_end("b2b");

    // Streaming against a reference argmax (lowest index wins ties).
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < OUTPUT_SIZE; j++) begin
        if ($urandom_range(0, 3) == 0) s_vec[k][j] = act_t'($urandom_range(0, 255));
        else                           s_vec[k][j] = act_t'(int'($urandom_range(0, 15)) - 8);
      end
      m_idx[k] = 0;
      m_max[k] = int'(s_vec[k][0]);
      m_az[k]  = (int'(s_vec[k][0]) <= 0) ? 1 : 0;
      for (int j = 1; j < OUTPUT_SIZE; j++) begin
        if (int'(s_vec[k][j]) > m_max[k]) begin
          m_max[k] = int'(s_vec[k][j]);
          m_idx[k] = j;
        end
        if (int'(s_vec[k][j]) > 0) m_az[k] = 0;
      end
    end
    cyc  = 0;
    nin  = 0;
    nout = 0;
    last = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = s_vec[0];
    #1;
    adv = bus.in_valid && bus.in_ready;
    while (nout < 20 && cyc < 400) begin
      @(negedge clk);
      if (adv) begin
        nin++;
        if (nin < 20) bus.in_data = s_vec[nin];
        else          bus.in_valid = 1'b0;
      end
      #1;
      cyc++;
      if (bus.out_valid) begin
        check("stream_idx", bus.out_idx, m_idx[nout]);
        check("stream_max", bus.out_max, m_max[nout]);
        check("stream_allzero", bus.out_all_zero, m_az[nout]);
        if (nout > 0) check("stream_gap", cyc - last, OUTPUT_SIZE);
        last = cyc;
        nout++;
      end
      adv = bus.in_valid && bus.in_ready;
    end
    check("stream_count", nout, 20);
    bus.in_valid = 1'b0;
    pulse_end("stream");

    // Reset two cycles into a scan discards the vector.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = '{8'sd50, 8'sd60, 8'sd70, 8'sd80, 8'sd90};
    #1;
    check("abort_ready", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_rst_valid", bus.out_valid, 0);
    check("abort_rst_idx", bus.out_idx, 0);
    check("abort_rst_max", bus.out_max, 0);
    check("abort_rst_allzero", bus.out_all_zero, 0);
    check("abort_rst_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      check("abort_quiet", bus.out_valid, 0);
    end
    run_vec("post_rst", '{8'sd8, 8'sd0, 8'sd0, 8'sd0, 8'sd0}, 0, 8, 0);
    pulse_end("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
